main_memory_responder: RTL and testbench
========================================

Name: main_memory_responder

Overview:
- Main-memory model and controller on the memory side of the cache's line-refill interface.
- Serves 4-beat, 64-bit line bursts: critical-word-first reads for misses, aligned writebacks for evictions.
- Fixed, parameterised access latency.
- Replaces the bench's combinational RAM lookup so cache miss timing is realistic.

Parameters:
- ADDR_WORDS, 65536: depth of backing store in 64-bit words (power of two); word index = address[31:3] mod ADDR_WORDS.
- LATENCY, 4: cycles from request handshake to first read beat, and from last write beat to wr_done (>=1).

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-low.
- req_valid, input, 1: cache request valid.
- req_ready, output, 1: responder can accept a request.
- req_write, input, 1: 1 = writeback, 0 = refill read.
- req_address, input, 32: byte address. Fields are tag[31:14], set[13:5], block[4:3]; [2:0] ignored.
- wr_valid, input, 1: writeback data beat valid.
- wr_ready, output, 1: responder accepts a writeback beat.
- wr_data, input, 64: writeback beat data.
- wr_done, output, 1: one-cycle pulse, writeback committed.
- rd_valid, output, 1: read beat valid (no backpressure; the cache must take it).
- rd_data, output, 64: read beat data.
- rd_last, output, 1: marks the 4th read beat.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; req_ready=1, wr_ready=0, wr_done=0, rd_valid=0, rd_last=0, rd_data=0.
  - Memory contents are not altered.
- Simulation initial contents: word i = i, zero-extended to 64 bits.
- Handshake: a request is accepted on an edge with req_valid && req_ready. At that edge the block latches:
  - line = req_address[31:5]
  - start_beat = req_address[4:3]
  - req_write
- req_ready is high only in IDLE.
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT, WR_DONE.
- IDLE:
  - On an accepted read, go to RD_WAIT with the counter loaded.
  - On an accepted write, go to WR_BURST.
- RD_WAIT: count down. The first rd_valid is high exactly LATENCY cycles after the handshake edge (LATENCY=1 means the next cycle).
- RD_BURST:
  - Four consecutive cycles with rd_valid=1.
  - Beat k carries word {line, (start_beat+k) mod 4}; the beat index wraps within the line.
  - rd_last=1 on k=3 only. Next state is IDLE, so req_ready=1 in the cycle after rd_last.
- WR_BURST:
  - wr_ready=1. Each edge with wr_valid writes wr_data to word {line, beat}, beat counting 0,1,2,3 (aligned; start_beat ignored).
  - wr_valid low stalls the burst with no write.
  - After beat 3 is written, wr_ready drops and the FSM enters WR_WAIT.
- WR_WAIT: LATENCY cycles, then WR_DONE.
- WR_DONE: wr_done=1 for exactly one cycle, then IDLE.
- Outputs are registered. rd_data is 0 whenever rd_valid=0.
- Address aliasing: word indices at or above ADDR_WORDS wrap modulo ADDR_WORDS. No error is flagged.
- req_valid outside IDLE is ignored; it is not queued.
- wr_valid outside WR_BURST is ignored.
- A read of a line whose writeback has just completed (after wr_done) returns the new data.
- Reset mid-burst:
  - The burst is aborted and the FSM returns to IDLE.
  - No further beats or wr_done are produced.
  - Write beats already committed remain in memory.
- All arithmetic is unsigned:
  - beat counter is 2 bits and wraps naturally;
  - latency counter width is clog2(LATENCY+1).

Test Plan:
- Reset, then read request at 0x00004028 (tag1/set1/block1) at edge T, LATENCY=4 -> rd_valid at T+4..T+7 with data 2053, 2054, 2055, 2052; rd_last only at T+7; req_ready=1 at T+8.
- Back-to-back: the same read is issued again on the first cycle req_ready returns high -> identical 4 beats and timing. req_valid held high during the previous burst is not accepted early.
- Writeback to 0x00000100 with beats 0xA0, 0xA1, 0xA2, 0xA3 (one idle wr_valid cycle between beats 1 and 2) -> wr_done pulses once, LATENCY+1 cycles after the last beat. A read at 0x00000110 then returns 0xA2, 0xA3, 0xA0, 0xA1.
- Aliasing: read at 0x00080000 with ADDR_WORDS=65536 -> beats 0, 1, 2, 3 (words 0..3).
- Reset asserted for one cycle after the 2nd read beat -> no further rd_valid; all outputs at reset values; the next request is served normally.
- Reset after 2 of 4 write beats to 0x00000200 (0xB0, 0xB1) -> no wr_done. A subsequent read at 0x00000200 returns 0xB0, 0xB1, 66, 67.

Source files
------------

// File: rtl/main_memory_responder_if.sv
// Line-refill bus between the cache (master) and main memory (slave).
interface main_memory_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic        wr_done;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        rd_last;

    modport master (
        output req_valid, req_write, req_address, wr_valid, wr_data,
        input  req_ready, wr_ready, wr_done, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  req_valid, req_write, req_address, wr_valid, wr_data,
        output req_ready, wr_ready, wr_done, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/main_memory_responder.sv
// Main-memory model: 4-beat 64-bit line bursts with fixed access latency.
// Reads are critical-word-first (wrapping within the line); writebacks are aligned.
module main_memory_responder #(
    parameter int unsigned ADDR_WORDS = 65536,
    parameter int unsigned LATENCY    = 4
) (
    input logic                    clock,
    input logic                    reset,
    main_memory_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(ADDR_WORDS);
    localparam int unsigned LW = $clog2(LATENCY + 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StRdWait  = 3'd1;
    localparam logic [2:0] StRdBurst = 3'd2;
    localparam logic [2:0] StWrBurst = 3'd3;
    localparam logic [2:0] StWrWait  = 3'd4;
    localparam logic [2:0] StWrDone  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [26:0]   line_q, line_d;
    logic [1:0]    start_q, start_d;
    logic [1:0]    beat_q, beat_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    logic          wr_done_q, wr_done_d;
    logic          req_ready_q, req_ready_d;
    logic          wr_ready_q, wr_ready_d;
    logic [63:0]   rd_data_q;
    logic          rd_emit;
    logic          wr_en;

    logic [1:0]    rd_blk;
    logic [28:0]   rd_word;
    logic [28:0]   wr_word;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          unused_bits;

    // Storage holds data XOR word index, so an all-zero power-up image reads back as word i = i.
    logic [63:0]   mem_q [ADDR_WORDS];

    assign rd_blk  = start_q + beat_q;
    assign rd_word = {line_q, rd_blk};
    assign wr_word = {line_q, beat_q};
    // Upper word-index bits are dropped: addresses alias modulo ADDR_WORDS.
    assign rd_idx  = rd_word[AW-1:0];
    assign wr_idx  = wr_word[AW-1:0];

    assign unused_bits = ^{bus.req_address[2:0], rd_word[28:AW], wr_word[28:AW]};

    assign bus.req_ready = req_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.wr_done   = wr_done_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.rd_data   = rd_data_q;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        start_d    = start_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        wr_done_d  = 1'b0;
        rd_emit    = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    line_d  = bus.req_address[31:5];
                    start_d = bus.req_address[4:3];
                    beat_d  = 2'd0;
                    if (bus.req_write) begin
                        state_d = StWrBurst;
                    end else begin
                        state_d = StRdWait;
                        // Loaded with LATENCY-1 so beat 0 is registered on the LATENCY-th edge.
                        lat_d   = LW'(LATENCY - 1);
                    end
                end
            end
            StRdWait: begin
                if (lat_q == '0) begin
                    rd_emit = 1'b1;
                    state_d = StRdBurst;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            StRdBurst: begin
                if (rd_last_q) begin
                    state_d = StIdle;
                end else begin
                    rd_emit = 1'b1;
                end
            end
            StWrBurst: begin
                if (bus.wr_valid) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = StWrWait;
                        lat_d   = LW'(LATENCY);
                    end
                end
            end
            StWrWait: begin
                if (lat_q == '0) begin
                    state_d   = StWrDone;
                    wr_done_d = 1'b1;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            StWrDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rd_emit) begin
            rd_valid_d = 1'b1;
            rd_last_d  = (beat_q == 2'd3);
            beat_d     = beat_q + 2'd1;
        end

        req_ready_d = (state_d == StIdle);
        wr_ready_d  = (state_d == StWrBurst);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            line_q      <= '0;
            start_q     <= '0;
            beat_q      <= '0;
            lat_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            req_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            start_q     <= start_d;
            beat_q      <= beat_d;
            lat_q       <= lat_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            wr_done_q   <= wr_done_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
        end
    end

    // Read-beat data register; forced to zero whenever no beat is presented.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_emit) begin
            rd_data_q <= mem_q[rd_idx] ^ 64'(rd_idx);
        end else begin
            rd_data_q <= '0;
        end
    end

    // Writeback beat commit; a reset edge aborts the burst without writing.
    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            mem_q[wr_idx] <= bus.wr_data ^ 64'(wr_idx);
        end
    end
endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench: read beats are scoreboarded against a reference memory model,
// handshake/latency timing is checked cycle by cycle in the stimulus tasks.
module tb_main_memory_responder;
    localparam int LAT   = 4;
    localparam int WORDS = 65536;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic clock;
    logic reset;

    main_memory_responder_if bus ();

    main_memory_responder #(
        .ADDR_WORDS (WORDS),
        .LATENCY    (LAT)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    bit    mon_en   = 1'b0;
    beat_t exp_q[$];
    logic [63:0] model [int unsigned];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] mem_word(input int unsigned idx);
        if (model.exists(idx)) return model[idx];
        return 64'(idx);
    endfunction

    // Queue the expected data of the first nbeats beats of a critical-word-first read.
    task automatic push_read(input logic [31:0] addr, input int nbeats);
        int unsigned line;
        int unsigned blk;
        int unsigned idx;
        beat_t       e;
        line = 32'(addr >> 5);
        for (int k = 0; k < nbeats; k++) begin
            blk    = (32'(addr[4:3]) + 32'(k)) & 32'd3;
            idx    = ((line << 2) | blk) % WORDS;
            e.data = mem_word(idx);
            e.last = (k == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("req_ready_wait", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        check({pfx, "_wr_ready"},  64'(bus.wr_ready),  64'd0);
        check({pfx, "_wr_done"},   64'(bus.wr_done),   64'd0);
        check({pfx, "_rd_valid"},  64'(bus.rd_valid),  64'd0);
        check({pfx, "_rd_last"},   64'(bus.rd_last),   64'd0);
        check({pfx, "_rd_data"},   bus.rd_data,        64'd0);
    endtask

    // Called at a negedge with req_ready high; handshake lands on the next posedge (T).
    task automatic issue_read(input logic [31:0] addr, input bit hold);
        push_read(addr, 4);
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b0;
        bus.req_address = addr;
        @(negedge clock);
        if (!hold) bus.req_valid = 1'b0;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clock);
            check($sformatf("rd_valid_T+%0d", k), 64'(bus.rd_valid),
                  64'(k >= LAT && k < LAT + 4));
            check($sformatf("rd_last_T+%0d", k), 64'(bus.rd_last), 64'(k == LAT + 3));
            check($sformatf("req_ready_T+%0d", k), 64'(bus.req_ready), 64'(k == LAT + 4));
        end
    endtask

    // Aligned writeback of base+b; a one-cycle wr_valid gap precedes beat 'gap'.
    task automatic write_burst(input logic [31:0] addr, input logic [63:0] base,
                               input int nbeats, input int gap);
        int unsigned line;
        line = 32'(addr >> 5);
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b1;
        bus.req_address = addr;
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        check("wr_ready_open", 64'(bus.wr_ready), 64'd1);
        for (int b = 0; b < nbeats; b++) begin
            if (b == gap) begin
                bus.wr_valid = 1'b0;
                bus.wr_data  = '1;
                @(negedge clock);
                check("wr_ready_stall", 64'(bus.wr_ready), 64'd1);
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + 64'(b);
            @(negedge clock);
            model[((line << 2) | 32'(b)) % WORDS] = base + 64'(b);
        end
        bus.wr_valid = 1'b0;
        if (nbeats == 4) begin
            // Last beat was taken at edge E; wr_done is expected after edge E+LAT+1.
            check("wr_ready_closed", 64'(bus.wr_ready), 64'd0);
            // Stray beats while waiting must not reach memory.
            bus.wr_valid = 1'b1;
            bus.wr_data  = 64'hDEAD_BEEF;
            for (int k = 1; k <= LAT + 2; k++) begin
                @(negedge clock);
                check($sformatf("wr_done_E+%0d", k), 64'(bus.wr_done), 64'(k == LAT + 1));
                check($sformatf("wr_req_ready_E+%0d", k), 64'(bus.req_ready),
                      64'(k == LAT + 2));
            end
            bus.wr_valid = 1'b0;
        end
    endtask

    // Read-beat scoreboard and idle-bus monitor.
    always @(negedge clock) begin
        beat_t e;
        if (mon_en) begin
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 64'(bus.rd_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", bus.rd_data, e.data);
                    check("rd_last", 64'(bus.rd_last), 64'(e.last));
                end
            end else begin
                check("rd_idle_data", bus.rd_data, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_address = '0;
        bus.wr_valid    = 1'b0;
        bus.wr_data     = '0;
        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clock);

        // Critical-word-first refill: words 2053, 2054, 2055, 2052.
        wait_ready();
        issue_read(32'h0000_4028, 1'b0);

        // Back-to-back with req_valid held through the first burst.
        wait_ready();
        issue_read(32'h0000_4028, 1'b1);
        issue_read(32'h0000_4028, 1'b0);

        // Writeback with a stall, then a wrapped read of the new line.
        wait_ready();
        write_burst(32'h0000_0100, 64'hA0, 4, 2);
        wait_ready();
        issue_read(32'h0000_0110, 1'b0);

        // Aliasing: word 65536 wraps to word 0.
        wait_ready();
        issue_read(32'h0008_0000, 1'b0);

        // Reset one cycle after the second read beat.
        wait_ready();
        push_read(32'h0000_0040, 2);
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b0;
        bus.req_address = 32'h0000_0040;
        @(negedge clock);
        bus.req_valid = 1'b0;
        repeat (LAT + 1) @(negedge clock);
        check("mid_rd_beat2", 64'(bus.rd_valid), 64'd1);
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("rd_abort");
        reset = 1'b1;
        repeat (LAT + 4) begin
            @(negedge clock);
            check("rd_abort_quiet", 64'(bus.rd_valid), 64'd0);
        end
        wait_ready();
        issue_read(32'h0000_0040, 1'b0);

        // Reset after two of four write beats: committed beats persist, no wr_done.
        wait_ready();
        write_burst(32'h0000_0200, 64'hB0, 2, -1);
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("wr_abort");
        reset = 1'b1;
        repeat (LAT + 3) begin
            @(negedge clock);
            check("wr_abort_no_done", 64'(bus.wr_done), 64'd0);
        end
        wait_ready();
        issue_read(32'h0000_0200, 1'b0);

        repeat (2) @(negedge clock);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
